// File: rtl/rc4_stream_core.sv
// rc4_stream_core: parametrised RC4 engine with variable key length, configurable
// data width and optional keystream drop. PRGA state persists across words.
module rc4_stream_core #(
  parameter int unsigned KEY_BYTES  = 4,
  parameter int unsigned DATA_BYTES = 4,
  parameter int unsigned DROP_N     = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key_load,
  input  logic [8*KEY_BYTES-1:0]  key,
  input  logic [5:0]              key_len,
  output logic                    key_ready,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [8*DATA_BYTES-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [8*DATA_BYTES-1:0] out_data
);

  localparam int unsigned DW  = 8 * DATA_BYTES;
  localparam int unsigned KIW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam int unsigned BIW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam int unsigned CW  = 11;

  localparam logic [CW-1:0]  LAST_256  = CW'(255);
  localparam logic [CW-1:0]  DROP_LAST = CW'((DROP_N == 0) ? 0 : DROP_N - 1);
  localparam logic [BIW-1:0] BIDX_LAST = BIW'(DATA_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    KSA   = 3'd2,
    DROP  = 3'd3,
    READY = 3'd4,
    GEN   = 3'd5,
    OUT   = 3'd6
  } state_t;

  state_t state_q, state_d;

  // Permutation table; contents are don't-care until INIT rewrites them
  logic [7:0]     s_mem [256];
  logic [7:0]     key_b [KEY_BYTES];
  logic [KIW-1:0] klast_q;
  logic [KIW-1:0] kidx_q;
  logic [CW-1:0]  cnt_q;
  logic [BIW-1:0] bidx_q;
  logic [7:0]     i_q, j_q;
  logic [DW-1:0]  data_q;

  logic [5:0]     eff_len;
  logic [KIW-1:0] klast_new;
  logic           ksa_step;
  logic           swap_en;
  logic [7:0]     a_idx, a_val, j_nx, b_val, t_idx, ks;
  logic [DW-1:0]  word_x;

  // Effective key length: 0 or oversize means the full key register
  always_comb begin
    eff_len = key_len;
    if (key_len == 6'd0 || key_len > 6'(KEY_BYTES)) begin
      eff_len = 6'(KEY_BYTES);
    end
    klast_new = KIW'(eff_len - 6'd1);
  end

  // Shared swap datapath: KSA uses (l, j+S[l]+K), PRGA uses (i+1, j+S[i+1])
  always_comb begin
    ksa_step = (state_q == KSA);
    swap_en  = (state_q == KSA) || (state_q == DROP) || (state_q == GEN);
    a_idx    = ksa_step ? cnt_q[7:0] : (i_q + 8'd1);
    a_val    = s_mem[a_idx];
    j_nx     = j_q + a_val + (ksa_step ? key_b[kidx_q] : 8'd0);
    b_val    = s_mem[j_nx];
    t_idx    = a_val + b_val;
    // Keystream byte is read from the post-swap table, so forward the swapped pair
    if (t_idx == a_idx) begin
      ks = b_val;
    end else if (t_idx == j_nx) begin
      ks = a_val;
    end else begin
      ks = s_mem[t_idx];
    end
    word_x = data_q ^ (DW'(ks) << {bidx_q, 3'b000});
  end

  // Next-state logic; key_load overrides every state and handshake
  always_comb begin
    state_d = state_q;
    if (key_load) begin
      state_d = INIT;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        INIT:    if (cnt_q == LAST_256) state_d = KSA;
        KSA:     if (cnt_q == LAST_256) state_d = (DROP_N == 0) ? READY : DROP;
        DROP:    if (cnt_q == DROP_LAST) state_d = READY;
        READY:   if (in_valid) state_d = GEN;
        GEN:     if (bidx_q == BIDX_LAST) state_d = OUT;
        OUT:     if (out_ready) state_d = READY;
        default: state_d = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered handshake/status outputs decoded from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_ready <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      key_ready <= (state_d == READY) || (state_d == GEN) || (state_d == OUT);
      in_ready  <= (state_d == READY);
      out_valid <= (state_d == OUT);
    end
  end

  // Key, indices, counters and data word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < int'(KEY_BYTES); n++) key_b[n] <= 8'd0;
      klast_q  <= '0;
      kidx_q   <= '0;
      cnt_q    <= '0;
      bidx_q   <= '0;
      i_q      <= 8'd0;
      j_q      <= 8'd0;
      data_q   <= '0;
      out_data <= '0;
    end else if (key_load) begin
      for (int n = 0; n < int'(KEY_BYTES); n++) key_b[n] <= key[8*n +: 8];
      klast_q <= klast_new;
      kidx_q  <= '0;
      cnt_q   <= '0;
      i_q     <= 8'd0;
      j_q     <= 8'd0;
    end else begin
      case (state_q)
        INIT: begin
          cnt_q <= (cnt_q == LAST_256) ? '0 : cnt_q + CW'(1);
        end
        KSA: begin
          cnt_q  <= (cnt_q == LAST_256) ? '0 : cnt_q + CW'(1);
          kidx_q <= (kidx_q == klast_q) ? '0 : kidx_q + KIW'(1);
          // PRGA starts from j=0 once the schedule is complete
          j_q    <= (cnt_q == LAST_256) ? 8'd0 : j_nx;
        end
        DROP: begin
          i_q   <= a_idx;
          j_q   <= j_nx;
          cnt_q <= cnt_q + CW'(1);
        end
        READY: begin
          if (in_valid) begin
            data_q <= in_data;
            bidx_q <= '0;
          end
        end
        GEN: begin
          i_q    <= a_idx;
          j_q    <= j_nx;
          data_q <= word_x;
          bidx_q <= bidx_q + BIW'(1);
          if (bidx_q == BIDX_LAST) out_data <= word_x;
        end
        default: ;
      endcase
    end
  end

  // Table writes: identity fill during INIT, one swap per KSA/PRGA step
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      s_mem[cnt_q[7:0]] <= cnt_q[7:0];
    end else if (swap_en) begin
      s_mem[a_idx] <= b_val;
      s_mem[j_nx]  <= a_val;
    end
  end

endmodule
